// File: rtl/vc_credit_rx_buffer_pkg.sv
// Shared chiplet flit types used by the credit-based link receive buffer.
package vc_credit_rx_buffer_pkg;

    localparam int unsigned VC_W      = 2;
    localparam int unsigned PAYLOAD_W = 16;

    typedef struct packed {
        logic [VC_W-1:0] vc;
        logic            is_head;
        logic            is_tail;
    } flit_metadata_t;

    typedef struct packed {
        flit_metadata_t         metadata;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

endpackage

// File: rtl/vc_credit_rx_buffer_if.sv
// Link-side and crossbar-side signals of the per-VC receive buffer.
interface vc_credit_rx_buffer_if #(
    parameter int unsigned NUM_VCS = 2
);
    import vc_credit_rx_buffer_pkg::*;

    flit_t              in_flit;
    logic               in_valid;
    flit_t              out_flit [NUM_VCS];
    logic [NUM_VCS-1:0] out_empty;
    logic [NUM_VCS-1:0] pop;
    logic [NUM_VCS-1:0] credit_granted;
    logic [NUM_VCS-1:0] overflow;

    modport master (
        output in_flit, in_valid, pop,
        input  out_flit, out_empty, credit_granted, overflow
    );

    modport slave (
        input  in_flit, in_valid, pop,
        output out_flit, out_empty, credit_granted, overflow
    );

endinterface

// File: rtl/vc_credit_rx_buffer_vc_fifo.sv
// Single-VC circular FIFO; a push into a full FIFO is taken only alongside a real pop.
module vc_credit_rx_buffer_vc_fifo
    import vc_credit_rx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  flit_t            din,
    output flit_t            head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flit_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    // Explicit wrap so non-power-of-2 depths never index past DEPTH-1
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop_c) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_credit_rx_buffer.sv
// Receive end of the credit-based flit link: per-VC FIFOs plus batched credit return.
module vc_credit_rx_buffer
    import vc_credit_rx_buffer_pkg::*;
#(
    parameter int unsigned NUM_VCS      = 2,
    parameter int unsigned BUFFER_SIZE  = 8,
    parameter int unsigned CREDIT_BATCH = 1,
    parameter bit          OVF_ERROR    = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    vc_credit_rx_buffer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);

    logic [NUM_VCS-1:0] push_c;
    logic [NUM_VCS-1:0] full_c;
    logic [NUM_VCS-1:0] empty_c;
    logic [NUM_VCS-1:0] pop_ok_c;
    logic [NUM_VCS-1:0] ovf_c;
    logic [CNT_W-1:0]   freed_nxt_c [NUM_VCS];
    logic [CNT_W-1:0]   count       [NUM_VCS];
    logic [CNT_W-1:0]   freed       [NUM_VCS];
    logic [NUM_VCS-1:0] credit_q;
    logic [NUM_VCS-1:0] ovf_q;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_fifo
        vc_credit_rx_buffer_vc_fifo #(
            .DEPTH (BUFFER_SIZE),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk   (clk),
            .n_rst (n_rst),
            .push  (push_c[v]),
            .pop   (bus.pop[v]),
            .din   (bus.in_flit),
            .head  (bus.out_flit[v]),
            .full  (full_c[v]),
            .empty (empty_c[v]),
            .count (count[v])
        );
    end

    // Steer the flit by VC; out-of-range VCs match no FIFO and are dropped silently
    always_comb begin
        push_c      = '0;
        pop_ok_c    = '0;
        ovf_c       = '0;
        freed_nxt_c = '{default: '0};
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            push_c[v]      = bus.in_valid && (bus.in_flit.metadata.vc == VC_W'(v));
            pop_ok_c[v]    = bus.pop[v] && !empty_c[v];
            ovf_c[v]       = push_c[v] && full_c[v] && !pop_ok_c[v];
            freed_nxt_c[v] = freed[v] + 1'b1;
        end
    end

    // Freed entries accumulate until a whole batch can be returned as one pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            credit_q <= '0;
            ovf_q    <= '0;
            freed    <= '{default: '0};
        end else begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= 1'b0;
                if (pop_ok_c[v]) begin
                    if (freed_nxt_c[v] >= CNT_W'(CREDIT_BATCH)) begin
                        credit_q[v] <= 1'b1;
                        freed[v]    <= freed_nxt_c[v] - CNT_W'(CREDIT_BATCH);
                    end else begin
                        freed[v]    <= freed_nxt_c[v];
                    end
                end
                if (ovf_c[v]) begin
                    ovf_q[v] <= 1'b1;
                end
            end
        end
    end

    assign bus.out_empty      = empty_c;
    assign bus.credit_granted = credit_q;
    assign bus.overflow       = ovf_q;

    // Simulation-only protocol checks
    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (OVF_ERROR && ovf_c[v]) begin
                    $error("vc %0d overflow: flit dropped", v);
                end
                assert (32'(count[v]) + 32'(freed[v]) <= BUFFER_SIZE)
                    else $error("vc %0d count+freed exceeds buffer size", v);
            end
        end
    end

endmodule

// File: tb/tb_vc_credit_rx_buffer.sv
// Directed bench: per-flit credit instance (dut1) and batch-of-6 instance (dut6).
module tb_vc_credit_rx_buffer;
    import vc_credit_rx_buffer_pkg::*;

    logic clk;
    logic n_rst1;
    logic n_rst6;
    int   n_cmp;
    int   n_bad;

    vc_credit_rx_buffer_if #(.NUM_VCS(2)) bus1 ();
    vc_credit_rx_buffer_if #(.NUM_VCS(2)) bus6 ();

    vc_credit_rx_buffer #(
        .NUM_VCS(2), .BUFFER_SIZE(8), .CREDIT_BATCH(1), .OVF_ERROR(1'b0)
    ) u_dut1 (
        .clk   (clk),
        .n_rst (n_rst1),
        .bus   (bus1.slave)
    );

    vc_credit_rx_buffer #(
        .NUM_VCS(2), .BUFFER_SIZE(8), .CREDIT_BATCH(6), .OVF_ERROR(1'b1)
    ) u_dut6 (
        .clk   (clk),
        .n_rst (n_rst6),
        .bus   (bus6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  vc;
        logic [15:0] data;
        logic [1:0]  pop;
        logic [1:0]  empty;
        logic        chk0;
        logic [15:0] h0;
        logic        chk1;
        logic [15:0] h1;
        logic [1:0]  credit;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic v, input logic [1:0] vc, input logic [15:0] d,
                                input logic [1:0] p, input logic [1:0] e,
                                input logic c0, input logic [15:0] h0,
                                input logic c1, input logic [15:0] h1,
                                input logic [1:0] cr);
        vec_t r;
        r.valid = v;  r.vc = vc;   r.data = d;  r.pop = p;  r.empty = e;
        r.chk0  = c0; r.h0 = h0;   r.chk1 = c1; r.h1 = h1;  r.credit = cr;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s6, input logic v, input logic [1:0] vc,
                         input logic [15:0] d, input logic [1:0] p);
        flit_t f;
        f              = '0;
        f.metadata.vc  = vc;
        f.payload      = d;
        if (s6) begin
            bus6.in_valid = v; bus6.in_flit = f; bus6.pop = p;
        end else begin
            bus1.in_valid = v; bus1.in_flit = f; bus1.pop = p;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] head_of(input bit s6, input int v);
        return s6 ? bus6.out_flit[v].payload : bus1.out_flit[v].payload;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        n_rst1 = 1'b0;
        n_rst6 = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 2'd0, 16'h0, 2'b00);

        vecs[0]  = mk(1, 2'd1, 16'h00A1, 2'b00, 2'b01, 0, 16'h0,   1, 16'h00A1, 2'b00);
        vecs[1]  = mk(1, 2'd1, 16'h00A2, 2'b00, 2'b01, 0, 16'h0,   1, 16'h00A1, 2'b00);
        vecs[2]  = mk(1, 2'd1, 16'h00A3, 2'b00, 2'b01, 0, 16'h0,   1, 16'h00A1, 2'b00);
        vecs[3]  = mk(1, 2'd0, 16'h00B0, 2'b00, 2'b00, 1, 16'hB0,  1, 16'h00A1, 2'b00);
        vecs[4]  = mk(1, 2'd0, 16'h00B1, 2'b00, 2'b00, 1, 16'hB0,  1, 16'h00A1, 2'b00);
        vecs[5]  = mk(1, 2'd0, 16'h00B2, 2'b00, 2'b00, 1, 16'hB0,  1, 16'h00A1, 2'b00);
        vecs[6]  = mk(1, 2'd0, 16'h00B3, 2'b00, 2'b00, 1, 16'hB0,  1, 16'h00A1, 2'b00);
        vecs[7]  = mk(0, 2'd0, 16'h0000, 2'b01, 2'b00, 1, 16'hB1,  1, 16'h00A1, 2'b01);
        vecs[8]  = mk(0, 2'd0, 16'h0000, 2'b01, 2'b00, 1, 16'hB2,  1, 16'h00A1, 2'b01);
        vecs[9]  = mk(0, 2'd0, 16'h0000, 2'b01, 2'b00, 1, 16'hB3,  1, 16'h00A1, 2'b01);
        vecs[10] = mk(0, 2'd0, 16'h0000, 2'b01, 2'b01, 0, 16'h0,   1, 16'h00A1, 2'b01);
        vecs[11] = mk(0, 2'd0, 16'h0000, 2'b01, 2'b01, 0, 16'h0,   1, 16'h00A1, 2'b00);
        vecs[12] = mk(1, 2'd0, 16'h00B4, 2'b00, 2'b00, 1, 16'hB4,  1, 16'h00A1, 2'b00);
        vecs[13] = mk(0, 2'd0, 16'h0000, 2'b11, 2'b01, 0, 16'h0,   1, 16'h00A2, 2'b11);
        vecs[14] = mk(0, 2'd0, 16'h0000, 2'b11, 2'b01, 0, 16'h0,   1, 16'h00A3, 2'b10);
        vecs[15] = mk(0, 2'd0, 16'h0000, 2'b10, 2'b11, 0, 16'h0,   0, 16'h0,    2'b10);
        vecs[16] = mk(0, 2'd0, 16'h0000, 2'b10, 2'b11, 0, 16'h0,   0, 16'h0,    2'b00);
        vecs[17] = mk(1, 2'd2, 16'h00C2, 2'b00, 2'b11, 0, 16'h0,   0, 16'h0,    2'b00);
        vecs[18] = mk(1, 2'd3, 16'h00C3, 2'b00, 2'b11, 0, 16'h0,   0, 16'h0,    2'b00);
        vecs[19] = mk(0, 2'd0, 16'h00DD, 2'b00, 2'b11, 0, 16'h0,   0, 16'h0,    2'b00);

        // Reset state of both instances
        #12;
        check("rst1 empty",    32'(bus1.out_empty),      32'h3);
        check("rst1 credit",   32'(bus1.credit_granted), 32'h0);
        check("rst1 overflow", 32'(bus1.overflow),       32'h0);
        check("rst1 flit0",    32'(bus1.out_flit[0]),    32'h0);
        check("rst6 empty",    32'(bus6.out_empty),      32'h3);
        check("rst6 flit1",    32'(bus6.out_flit[1]),    32'h0);
        @(negedge clk);
        n_rst1 = 1'b1;
        n_rst6 = 1'b1;
        @(negedge clk);

        // Table-driven per-flit credit, ordering, dual-VC and invalid-VC vectors
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, vecs[i].valid, vecs[i].vc, vecs[i].data, vecs[i].pop);
            step();
            check($sformatf("vec%0d empty", i),    32'(bus1.out_empty),      32'(vecs[i].empty));
            check($sformatf("vec%0d credit", i),   32'(bus1.credit_granted), 32'(vecs[i].credit));
            check($sformatf("vec%0d overflow", i), 32'(bus1.overflow),       32'h0);
            if (vecs[i].chk0) check($sformatf("vec%0d head0", i), 32'(head_of(1'b0, 0)), 32'(vecs[i].h0));
            if (vecs[i].chk1) check($sformatf("vec%0d head1", i), 32'(head_of(1'b0, 1)), 32'(vecs[i].h1));
        end

        // Full VC0: drop without pop, accept with simultaneous pop
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 2'd0, 16'h0100 + 16'(i), 2'b00);
            step();
        end
        check("full no ovf yet", 32'(bus1.overflow), 32'h0);
        drive(1'b0, 1'b1, 2'd0, 16'h01FF, 2'b00);
        step();
        check("full drop ovf",  32'(bus1.overflow),   32'h1);
        check("full drop head", 32'(head_of(1'b0, 0)), 32'h0100);
        drive(1'b0, 1'b1, 2'd0, 16'h0200, 2'b01);
        step();
        check("full pp head",   32'(head_of(1'b0, 0)), 32'h0101);
        check("full pp credit", 32'(bus1.credit_granted), 32'h1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d head", i), 32'(head_of(1'b0, 0)),
                  (i < 7) ? 32'h0101 + 32'(i) : 32'h0200);
            drive(1'b0, 1'b0, 2'd0, 16'h0, 2'b01);
            step();
            check($sformatf("drain%0d credit", i), 32'(bus1.credit_granted), 32'h1);
        end
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'b00);
        check("drain empty",      32'(bus1.out_empty), 32'h3);
        check("overflow sticky",  32'(bus1.overflow),  32'h1);

        // Batch of 6: fill 8, pop 8 -> one pulse after the 6th pop, 2 left pending
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 2'd0, 16'h0300 + 16'(i), 2'b00);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b6 pop%0d head", i), 32'(head_of(1'b1, 0)), 32'h0300 + 32'(i));
            drive(1'b1, 1'b0, 2'd0, 16'h0, 2'b01);
            step();
            check($sformatf("b6 pop%0d credit", i), 32'(bus6.credit_granted), (i == 5) ? 32'h1 : 32'h0);
        end
        check("b6 drained", 32'(bus6.out_empty), 32'h3);
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b1, 2'd0, 16'h0400 + 16'(j), 2'b00);
            step();
            drive(1'b1, 1'b0, 2'd0, 16'h0, 2'b01);
            step();
            check($sformatf("b6 pair%0d credit", j), 32'(bus6.credit_granted), (j == 3) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset with 5 queued entries and 3 freed
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 2'd0, 16'h0500 + 16'(i), 2'b00);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd0, 16'h0, 2'b01);
            step();
            check($sformatf("pre-rst pop%0d credit", i), 32'(bus6.credit_granted), 32'h0);
        end
        drive(1'b1, 1'b0, 2'd0, 16'h0, 2'b00);
        check("pre-rst head", 32'(head_of(1'b1, 0)), 32'h0503);
        #1 n_rst6 = 1'b0;
        #1;
        check("async rst empty",  32'(bus6.out_empty),      32'h3);
        check("async rst credit", 32'(bus6.credit_granted), 32'h0);
        check("async rst flit0",  32'(bus6.out_flit[0]),    32'h0);
        @(negedge clk);
        n_rst6 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 1'b1, 2'd0, 16'h0600 + 16'(j), 2'b00);
            step();
            check($sformatf("post-rst pair%0d head", j), 32'(head_of(1'b1, 0)), 32'h0600 + 32'(j));
            drive(1'b1, 1'b0, 2'd0, 16'h0, 2'b01);
            step();
            check($sformatf("post-rst pair%0d credit", j), 32'(bus6.credit_granted), (j == 5) ? 32'h1 : 32'h0);
        end
        drive(1'b1, 1'b0, 2'd0, 16'h0, 2'b00);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
